// File: rtl/div_share_sched.sv
// div_share_sched: round-robin scheduler sharing one pipelined divider
// Optional grant statistics: define DIV_SHARE_SCHED_STAT_EN
module div_share_sched #(
  parameter int NUM_W   = 40,
  parameter int DEN_W   = 32,
  parameter int DIV_LAT = 8,
  parameter int NREQ    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       req,
  input  logic [NUM_W-1:0] numer0,
  input  logic [NUM_W-1:0] numer1,
  input  logic [NUM_W-1:0] numer2,
  input  logic [DEN_W-1:0] denom0,
  input  logic [DEN_W-1:0] denom1,
  input  logic [DEN_W-1:0] denom2,
  output logic [2:0]       gnt,
  output logic [NUM_W-1:0] div_numer,
  output logic [DEN_W-1:0] div_denom,
  input  logic [NUM_W-1:0] div_quot,
  output logic             res_valid,
  output logic [1:0]       res_tag,
  output logic [NUM_W-1:0] res_q,
  output logic             res_dz,
  output logic             busy
`ifdef DIV_SHARE_SCHED_STAT_EN
  ,
  input  logic             stat_clr,
  output logic [47:0]      gnt_cnt
`endif
);

  localparam int NST = DIV_LAT + 1;

  typedef struct packed {
    logic       v;
    logic [1:0] tag;
    logic       dz;
  } tag_t;

  logic [2:0]       gnt_q, gnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [NUM_W-1:0] dn_q, dn_d;
  logic [DEN_W-1:0] dd_q, dd_d;
  tag_t [NST-1:0]   pipe_q, pipe_d;
  logic             rv_q, rv_d;
  logic [1:0]       rt_q, rt_d;
  logic [NUM_W-1:0] rq_q, rq_d;
  logic             rz_q, rz_d;

  logic [2:0]       elig;
  logic             found;
  logic [1:0]       win;
  logic [2:0]       s;
  logic [NUM_W-1:0] sel_n;
  logic [DEN_W-1:0] sel_d;
  logic             sel_z;
  logic             any_v;
  tag_t             last;

  // Round-robin search from the pointer over unmasked requests
  always_comb begin
    elig  = req & ~gnt_q & {3{en}};
    found = 1'b0;
    win   = 2'd0;
    s     = 3'd0;
    for (int k = 0; k < 3; k++) begin
      s = {1'b0, ptr_q} + 3'(k);
      if (s > 3'd2) s = s - 3'd3;
      if (!found && elig[s[1:0]]) begin
        found = 1'b1;
        win   = s[1:0];
      end
    end
  end

  // Operand mux for the winning requester
  always_comb begin
    sel_n = numer0;
    sel_d = denom0;
    case (win)
      2'd1: begin
        sel_n = numer1;
        sel_d = denom1;
      end
      2'd2: begin
        sel_n = numer2;
        sel_d = denom2;
      end
      default: begin
        sel_n = numer0;
        sel_d = denom0;
      end
    endcase
    sel_z = (sel_d == '0);
  end

  // Issue, tag pipe shift and result capture
  always_comb begin
    gnt_d = found ? (3'b001 << win) : 3'b000;
    ptr_d = ptr_q;
    dn_d  = dn_q;
    dd_d  = dd_q;
    if (found) begin
      ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
      dn_d  = sel_n;
      dd_d  = sel_z ? DEN_W'(1) : sel_d;
    end
    pipe_d[0] = '{v: found, tag: win, dz: found & sel_z};
    for (int k = 1; k < NST; k++) pipe_d[k] = pipe_q[k-1];
    last = pipe_q[NST-1];
    rv_d = last.v;
    rt_d = rt_q;
    rq_d = rq_q;
    rz_d = rz_q;
    if (last.v) begin
      rt_d = last.tag;
      rz_d = last.dz;
      rq_d = last.dz ? '1 : div_quot;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q  <= 3'b000;
      ptr_q  <= 2'd0;
      dn_q   <= '0;
      dd_q   <= DEN_W'(1);
      pipe_q <= '0;
      rv_q   <= 1'b0;
      rt_q   <= 2'd0;
      rq_q   <= '0;
      rz_q   <= 1'b0;
    end else begin
      gnt_q  <= gnt_d;
      ptr_q  <= ptr_d;
      dn_q   <= dn_d;
      dd_q   <= dd_d;
      pipe_q <= pipe_d;
      rv_q   <= rv_d;
      rt_q   <= rt_d;
      rq_q   <= rq_d;
      rz_q   <= rz_d;
    end
  end

  // In-flight detection across every tag stage
  always_comb begin
    any_v = 1'b0;
    for (int k = 0; k < NST; k++) any_v = any_v | pipe_q[k].v;
  end

  assign gnt       = gnt_q;
  assign div_numer = dn_q;
  assign div_denom = dd_q;
  assign res_valid = rv_q;
  assign res_tag   = rt_q;
  assign res_q     = rq_q;
  assign res_dz    = rz_q;
  assign busy      = (|gnt_q) | any_v;

`ifdef DIV_SHARE_SCHED_STAT_EN
  logic [15:0] cnt_q [3];
  logic [15:0] cnt_d [3];

  // Saturating grant counters, clear wins over increment
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      cnt_d[k] = cnt_q[k];
      if (stat_clr) cnt_d[k] = 16'h0000;
      else if (gnt_q[k] && cnt_q[k] != 16'hFFFF)
        cnt_d[k] = cnt_q[k] + 16'h0001;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) cnt_q[k] <= 16'h0000;
    end else begin
      for (int k = 0; k < 3; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign gnt_cnt = {cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_div_share_sched.sv
// Scoreboard bench for div_share_sched with an external divider model
// Reference: arbitration and results from plain arithmetic and a queue
module tb_div_share_sched;
  localparam int NUM_W = 40;
  localparam int DEN_W = 32;
  localparam int LAT   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [2:0] req = 3'b000;
  logic [NUM_W-1:0] n_a [3];
  logic [DEN_W-1:0] d_a [3];
  logic [2:0] gnt;
  logic [NUM_W-1:0] div_numer, div_quot;
  logic [DEN_W-1:0] div_denom;
  logic res_valid, res_dz, busy;
  logic [1:0] res_tag;
  logic [NUM_W-1:0] res_q;
`ifdef DIV_SHARE_SCHED_STAT_EN
  logic stat_clr = 1'b0;
  logic [47:0] gnt_cnt;
  int m_cnt [3];
`endif

  always #5 clk = ~clk;

  div_share_sched #(.NUM_W(NUM_W), .DEN_W(DEN_W), .DIV_LAT(LAT), .NREQ(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .numer0(n_a[0]), .numer1(n_a[1]), .numer2(n_a[2]),
    .denom0(d_a[0]), .denom1(d_a[1]), .denom2(d_a[2]),
    .gnt(gnt), .div_numer(div_numer), .div_denom(div_denom),
    .div_quot(div_quot), .res_valid(res_valid), .res_tag(res_tag),
    .res_q(res_q), .res_dz(res_dz), .busy(busy)
`ifdef DIV_SHARE_SCHED_STAT_EN
    , .stat_clr(stat_clr), .gnt_cnt(gnt_cnt)
`endif
  );

  logic [NUM_W-1:0] qp [LAT];
  always @(posedge clk) begin
    qp[0] <= (div_denom == 0) ? '1 : div_numer / NUM_W'(div_denom);
    for (int k = 1; k < LAT; k++) qp[k] <= qp[k-1];
  end
  assign div_quot = qp[LAT-1];

  typedef struct {
    int tag;
    bit dz;
    logic [NUM_W-1:0] q;
    int due;
  } exp_t;
  exp_t sbq [$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int m_p = 0;
  logic [2:0] m_gnt = 0;
  logic [NUM_W-1:0] m_dn = 0;
  logic [DEN_W-1:0] m_dd = 1;
  logic [1:0] l_tag = 0;
  logic [NUM_W-1:0] l_q = 0;
  logic l_dz = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    logic [2:0] el;
    int w;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      sbq.delete();
      m_p = 0; m_gnt = 0; m_dn = 0; m_dd = 1;
`ifdef DIV_SHARE_SCHED_STAT_EN
      for (int k = 0; k < 3; k++) m_cnt[k] = 0;
`endif
    end else begin
`ifdef DIV_SHARE_SCHED_STAT_EN
      for (int k = 0; k < 3; k++)
        if (stat_clr) m_cnt[k] = 0;
        else if (m_gnt[k] && m_cnt[k] < 65535) m_cnt[k]++;
`endif
      el = en ? (req & ~m_gnt) : 3'b000;
      w = -1;
      for (int k = 0; k < 3; k++)
        if (w < 0 && el[(m_p + k) % 3]) w = (m_p + k) % 3;
      m_gnt = 0;
      if (w >= 0) begin
        m_gnt[w] = 1'b1;
        e.tag = w;
        e.dz = (d_a[w] == 0);
        e.q = e.dz ? '1 : n_a[w] / NUM_W'(d_a[w]);
        e.due = cyc + LAT + 1;
        sbq.push_back(e);
        m_dn = n_a[w];
        m_dd = e.dz ? 1 : d_a[w];
        m_p = (w + 1) % 3;
      end
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      l_tag = 0; l_q = 0; l_dz = 0;
    end
    chk("gnt", 64'(gnt), 64'(m_gnt));
    chk("div_numer", 64'(div_numer), 64'(m_dn));
    chk("div_denom", 64'(div_denom), 64'(m_dd));
    if (res_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_res_valid", 64'(1), 64'(0));
      end else begin
        e = sbq.pop_front();
        chk("res_cycle", 64'(cyc), 64'(e.due));
        l_tag = 2'(e.tag); l_q = e.q; l_dz = e.dz;
      end
    end else begin
      chk("res_valid_low", 64'(res_valid), 64'(0));
      if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        chk("missing_res_valid", 64'(0), 64'(1));
        void'(sbq.pop_front());
      end
    end
    chk("res_tag", 64'(res_tag), 64'(l_tag));
    chk("res_q", 64'(res_q), 64'(l_q));
    chk("res_dz", 64'(res_dz), 64'(l_dz));
    chk("busy", 64'(busy), 64'((|m_gnt) || sbq.size() > 0));
`ifdef DIV_SHARE_SCHED_STAT_EN
    chk("gnt_cnt", 64'(gnt_cnt),
        64'({m_cnt[2][15:0], m_cnt[1][15:0], m_cnt[0][15:0]}));
`endif
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_gnt(int i);
    int t = 0;
    while (!gnt[i] && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("gnt_timeout", 64'(gnt[i]), 64'(1));
  endtask

  task automatic req_op(int i, logic [NUM_W-1:0] n, logic [DEN_W-1:0] d);
    n_a[i] = n;
    d_a[i] = d;
    req[i] = 1'b1;
    @(negedge clk);
    wait_gnt(i);
    req[i] = 1'b0;
  endtask

  initial begin
    logic [2:0] prev;
    int ng;
    for (int k = 0; k < 3; k++) begin
      n_a[k] = 0;
      d_a[k] = 1;
    end
    tick(3);
    rst_n = 1'b1;
    en = 1'b1;
    tick(2);

    req_op(0, 40'd36000, 32'd100);
    tick(LAT + 3);
    chk("single_q", 64'(res_q), 64'd360);
    chk("single_tag", 64'(res_tag), 64'd0);
    chk("single_dz", 64'(res_dz), 64'd0);

    req_op(2, 40'd5, 32'd0);
    chk("dz_denom", 64'(div_denom), 64'd1);
    tick(LAT + 3);
    chk("dz_q", 64'(res_q), 64'hFF_FFFF_FFFF);
    chk("dz_tag", 64'(res_tag), 64'd2);
    chk("dz_flag", 64'(res_dz), 64'd1);

    for (int k = 0; k < 3; k++) begin
      n_a[k] = 40'(1000 * (k + 1));
      d_a[k] = 32'(k + 3);
    end
    req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("contention_gnt", 64'(gnt), 64'(3'b001 << k));
      req[k] = 1'b0;
    end
    tick(LAT + 4);

    req = 3'b011;
    prev = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (gnt != 0) chk("fair_alternate", 64'(gnt == prev), 64'(0));
      if (gnt != 0) prev = gnt;
    end
    req = 3'b000;
    tick(LAT + 4);

    req_op(1, 40'd777, 32'd7);
    en = 1'b0;
    req[0] = 1'b1;
    n_a[0] = 40'd99;
    d_a[0] = 32'd9;
    ng = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt != 0) ng++;
    end
    chk("en_low_no_gnt", 64'(ng), 64'(0));
    chk("en_low_res_tag", 64'(res_tag), 64'd1);
    en = 1'b1;
    @(negedge clk);
    wait_gnt(0);
    req[0] = 1'b0;
    tick(LAT + 4);

    req = 3'b011;
    @(negedge clk);
    wait_gnt(1);
    req = 3'b000;
    tick(3);
    rst_n = 1'b0;
    tick(3);
    chk("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    tick(LAT + 6);

`ifdef DIV_SHARE_SCHED_STAT_EN
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    for (int k = 0; k < 5; k++) req_op(1, 40'd50, 32'd5);
    tick(2);
    chk("stat_req1", 64'(gnt_cnt[31:16]), 64'd5);
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    tick(1);
    chk("stat_clr", 64'(gnt_cnt), 64'd0);
    tick(LAT + 4);
`endif

    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if ($urandom_range(9, 0) == 0) en = ~en;
      for (int i = 0; i < 3; i++) begin
        if (req[i] && gnt[i]) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
          n_a[i] = {8'($urandom), 32'($urandom)};
          d_a[i] = ($urandom_range(5, 0) == 0) ? 32'd0 :
                   ($urandom_range(1, 0) == 0) ? 32'($urandom_range(999, 1)) :
                   32'($urandom);
        end else if (!req[i] && $urandom_range(2, 0) == 0) begin
          n_a[i] = {8'($urandom), 32'($urandom)};
          d_a[i] = ($urandom_range(5, 0) == 0) ? 32'd0 :
                   32'($urandom_range(9999, 1));
          req[i] = 1'b1;
        end
      end
    end
    req = 3'b000;
    en = 1'b1;
    tick(LAT + 6);
    chk("drain_empty", 64'(sbq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
